// File: rtl/sram_responder_if.sv
// CPU <-> SRAM responder bus. The master is the CPU side, the slave is the memory side.
// The we polarity follows the CPU: 1 = read, 0 = write.
interface sram_responder_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          ready;
  logic          addr_err;

  modport master (
    output addr,
    output we,
    output data_in,
    input  data_out,
    input  ready,
    input  addr_err
  );

  modport slave (
    input  addr,
    input  we,
    input  data_in,
    output data_out,
    output ready,
    output addr_err
  );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the CPU SRAM bus. It holds DEPTH words and performs one
// read or write per clock. After reset it optionally zero-scrubs the whole array before
// it raises ready.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// ST_CLEAR | scrubbing mem[clr_ptr] to 0, bus ignored, ready=0
// ST_RUN   | serving CPU reads/writes every edge, ready=1
module sram_responder #(
  parameter int DEPTH          = 4096,
  parameter int AW             = 12,
  parameter int DW             = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             reset,
  sram_responder_if.slave  bus
);

  localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW:0]   clr_ptr;
  logic [AW:0]   clr_ptr_nxt;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] stage1;
  logic [DW-1:0] stage2;
  logic          addr_err_q;

  logic          in_range;
  logic          is_write;

  // The compare is one bit wider than addr, so DEPTH == 2**AW never flags an error.
  assign in_range = ({1'b0, bus.addr} < DEPTH_W);

  // A write needs we to be a clean 0. An unknown we falls through to a read, so it can
  // never corrupt the array.
  always_comb begin
    is_write = 1'b0;
    if (bus.we == 1'b0) is_write = 1'b1;
  end

  // An out-of-range read returns 0 instead of aliasing onto a low address.
  assign rd_data = in_range ? mem[bus.addr[IW-1:0]] : '0;

  // State register and scrub pointer. The array itself has no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next state and the array write port: the scrub in CLEAR, the CPU writes in RUN.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    case (state)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_ptr[IW-1:0];
        clr_ptr_nxt = clr_ptr + PTR_ONE;
        if (clr_ptr == LAST_PTR) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (is_write && in_range) begin
          mem_we    = 1'b1;
          mem_waddr = bus.addr[IW-1:0];
          mem_wdata = bus.data_in;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
    // The array has no reset of its own, so it must not see writes while reset is held.
    if (reset) mem_we = 1'b0;
  end

  // Single write port into the array.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read pipe and error flag. Stage1 holds during writes and stage2 shifts on every RUN edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1     <= '0;
      stage2     <= '0;
      addr_err_q <= 1'b0;
    end else if (state == ST_RUN) begin
      addr_err_q <= ~in_range;
      if (!is_write) stage1 <= rd_data;
      stage2 <= stage1;
    end else begin
      addr_err_q <= 1'b0;
    end
  end

  assign bus.data_out = (READ_LATENCY == 2) ? stage2 : stage1;
  assign bus.ready    = (state == ST_RUN);
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder. Two instances share one bus stream:
//   dut0: READ_LATENCY=1, CLEAR_ON_RESET=1
//   dut1: READ_LATENCY=2, CLEAR_ON_RESET=0
// The driver pushes one expected entry per issued cycle. The monitor pops one entry
// after each clock edge and checks both instances against it.
module tb_sram_responder;
  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_responder_if #(.AW(AW), .DW(DW)) bus0 ();
  sram_responder_if #(.AW(AW), .DW(DW)) bus1 ();

  assign bus1.addr    = bus0.addr;
  assign bus1.we      = bus0.we;
  assign bus1.data_in = bus0.data_in;

  sram_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .READ_LATENCY(1), .CLEAR_ON_RESET(1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  sram_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .READ_LATENCY(2), .CLEAR_ON_RESET(0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  typedef struct {
    bit          chk0;
    logic [15:0] d0;
    bit          chk1;
    logic [15:0] d1;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Expected data_out of dut0, and the expected stage1 of dut1, each with a known flag.
  logic [15:0] hold0;
  bit          k_hold0;
  logic [15:0] s1_1;
  bit          k_s1_1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one bus cycle. e0/e1 are the hand-computed read results for dut0/dut1 and
  // k0/k1 say whether each one is known.
  task automatic op(input bit we, input logic [11:0] a, input logic [15:0] d,
                    input logic [15:0] e0, input bit k0,
                    input logic [15:0] e1, input bit k1);
    exp_t e;
    @(negedge clk);
    bus0.we      = we;
    bus0.addr    = a;
    bus0.data_in = d;
    if (we) begin
      hold0   = e0;
      k_hold0 = k0;
    end
    e.chk0 = k_hold0;
    e.d0   = hold0;
    e.chk1 = k_s1_1;
    e.d1   = s1_1;
    if (we) begin
      s1_1   = e1;
      k_s1_1 = k1;
    end
    e.err = (a >= DEPTH);
    sb.push_back(e);
  endtask

  task automatic wait_scrub();
    int n;
    bit quiet;
    n = 0;
    quiet = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus0.ready) break;
      if (bus0.data_out !== 16'h0 || bus0.addr_err !== 1'b0) quiet = 1'b0;
    end
    check("scrub_edges", n, 16);
    check("clear_quiet", quiet, 1);
    check("rdy1_noclear", bus1.ready, 1);
    hold0 = 16'h0; k_hold0 = 1'b1;
    s1_1  = 16'h0; k_s1_1  = 1'b1;
  endtask

  // Pulse reset while driving the given bus value, then wait out the scrub.
  task automatic do_reset(input bit we, input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    bus0.we      = we;
    bus0.addr    = a;
    bus0.data_in = d;
    reset        = 1'b1;
    #1;
    check("rst_rdy0", bus0.ready, 0);
    check("rst_do0", bus0.data_out, 0);
    check("rst_err0", bus0.addr_err, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_scrub();
  endtask

  // Monitor: one expected entry per edge, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (mon_e.chk0) check("rd0", bus0.data_out, mon_e.d0);
        if (mon_e.chk1) check("rd1", bus1.data_out, mon_e.d1);
        check("err0", bus0.addr_err, mon_e.err);
        check("err1", bus1.addr_err, mon_e.err);
        check("rdy0", bus0.ready, 1);
        check("rdy1", bus1.ready, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus0.we      = 1'b0;
    bus0.addr    = '0;
    bus0.data_in = '0;
    hold0 = 16'h0; k_hold0 = 1'b1;
    s1_1  = 16'h0; k_s1_1  = 1'b1;

    // Scrub after power-up. Every word reads back 0 on dut0; on dut1 only word 0 is known.
    do_reset(1'b0, 12'h000, 16'h0000);
    for (int i = 0; i < DEPTH; i++)
      op(1'b1, 12'(i), 16'h0, 16'h0000, 1'b1, 16'h0000, (i == 0));

    // An out-of-range read returns 0 and flags an error. An out-of-range write must not alias onto word 0.
    op(1'b0, 12'h000, 16'h1111, 16'h0, 1'b0, 16'h0, 1'b0);
    op(1'b1, 12'h020, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1);
    op(1'b0, 12'h020, 16'hAAAA, 16'h0, 1'b0, 16'h0, 1'b0);
    op(1'b1, 12'h000, 16'h0000, 16'h1111, 1'b1, 16'h1111, 1'b1);

    // Write then read back: latency 1 on dut0, and dut1 still holds the old value for one edge.
    op(1'b0, 12'h005, 16'h1234, 16'h0, 1'b0, 16'h0, 1'b0);
    op(1'b1, 12'h005, 16'h0000, 16'h1234, 1'b1, 16'h1234, 1'b1);

    // A back-to-back write and read of the same word.
    op(1'b0, 12'h00A, 16'hBEEF, 16'h0, 1'b0, 16'h0, 1'b0);
    op(1'b1, 12'h00A, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1);

    // Address boundaries: DEPTH-1 is valid; DEPTH and the maximum address are errors.
    op(1'b0, 12'h00F, 16'hCAFE, 16'h0, 1'b0, 16'h0, 1'b0);
    op(1'b1, 12'h00F, 16'h0000, 16'hCAFE, 1'b1, 16'hCAFE, 1'b1);
    op(1'b1, 12'h010, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1);
    op(1'b1, 12'hFFF, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1);
    op(1'b1, 12'h000, 16'h0000, 16'h1111, 1'b1, 16'h1111, 1'b1);

    // A write driven during CLEAR is ignored by dut0; dut1 is already in RUN and keeps it.
    do_reset(1'b0, 12'h003, 16'hFFFF);
    op(1'b1, 12'h003, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
    op(1'b1, 12'h005, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b1);

    // An asynchronous reset in mid-cycle drops ready (dut0) and data_out (both) at once.
    op(1'b0, 12'h00A, 16'hBEEF, 16'h0, 1'b0, 16'h0, 1'b0);
    op(1'b1, 12'h00A, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1);
    op(1'b0, 12'h007, 16'h5A5A, 16'h0, 1'b0, 16'h0, 1'b0);
    @(posedge clk);
    #3;
    check("pre_rst_do0", bus0.data_out, 16'hBEEF);
    reset = 1'b1;
    #1;
    check("mid_rst_rdy0", bus0.ready, 0);
    check("mid_rst_do0", bus0.data_out, 0);
    check("mid_rst_do1", bus1.data_out, 0);
    check("mid_rst_rdy1", bus1.ready, 1);
    @(negedge clk);
    reset = 1'b0;
    wait_scrub();
    op(1'b1, 12'h007, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, 1'b1);
    op(1'b1, 12'h000, 16'h0000, 16'h0000, 1'b1, 16'h1111, 1'b1);

    @(posedge clk);
    #5;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
